// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

    localparam int unsigned DEF_WIDTH = 16;

    // Iteration counter width able to hold 0..w.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    localparam int unsigned CNT_W = cnt_width(DEF_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH:0]   p_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH:0]   p_o,
    output logic             q_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] d_ext;

    assign shifted = {p_i, bit_i};
    assign d_ext   = {2'b00, d_i};
    assign q_o     = (shifted >= d_ext);
    // Partial remainder stays below the divisor, so the top bit always truncates to zero.
    assign p_o     = q_o ? (WIDTH+1)'(shifted - d_ext) : (WIDTH+1)'(shifted);

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (adds a sign-fix state).
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 ovf,
    output logic                 div_zero
);

    localparam int unsigned      CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   p_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] d_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             ovf_q;
    logic             dz_q;

`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};
    logic             neg_q_q;
    logic             neg_r_q;
    logic [WIDTH-1:0] raw_lo_q;
`endif

    logic [2*WIDTH-1:0] n_mag;
    logic [WIDTH-1:0]   d_mag;
    logic               early_ovf;
    logic [WIDTH:0]     p_d;
    logic               q_bit;

    // Operand magnitudes fed to the unsigned core.
    always_comb begin
        n_mag = dividend;
        d_mag = divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
        if (dividend[2*WIDTH-1]) n_mag = -dividend;
        if (divisor[WIDTH-1])    d_mag = -divisor;
`endif
    end

    assign early_ovf = (n_mag[2*WIDTH-1:WIDTH] >= d_mag);

    // lo_q shifts dividend bits out the top while quotient bits fill the bottom.
    div_step #(.WIDTH(WIDTH)) u_step (
        .p_i   (p_q),
        .bit_i (lo_q[WIDTH-1]),
        .d_i   (d_q),
        .p_o   (p_d),
        .q_o   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            p_q         <= '0;
            lo_q        <= '0;
            d_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            raw_lo_q    <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        if (divisor == '0) begin
                            dz_q        <= 1'b1;
                            ovf_q       <= 1'b0;
                            quot_q      <= ALL_ONES;
                            rem_q       <= dividend[WIDTH-1:0];
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else if (early_ovf) begin
                            dz_q        <= 1'b0;
                            ovf_q       <= 1'b1;
                            quot_q      <= ALL_ONES;
                            rem_q       <= dividend[WIDTH-1:0];
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            p_q     <= {1'b0, n_mag[2*WIDTH-1:WIDTH]};
                            lo_q    <= n_mag[WIDTH-1:0];
                            d_q     <= d_mag;
                            cnt_q   <= '0;
                            state_q <= S_CALC;
                        end
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_q_q  <= dividend[2*WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r_q  <= dividend[2*WIDTH-1];
                        raw_lo_q <= dividend[WIDTH-1:0];
`endif
                    end
                end

                S_CALC: begin
                    p_q   <= p_d;
                    lo_q  <= {lo_q[WIDTH-2:0], q_bit};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                        state_q     <= S_FIX;
`else
                        quot_q      <= {lo_q[WIDTH-2:0], q_bit};
                        rem_q       <= WIDTH'(p_d);
                        ovf_q       <= 1'b0;
                        dz_q        <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
`endif
                    end
                end

`ifdef SEQ_DIVIDER_SIGNED_EN
                // Apply signs; a negative quotient may reach -2^(W-1), a positive one may not.
                S_FIX: begin
                    dz_q        <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                    if (neg_q_q ? (lo_q > MIN_MAG) : lo_q[WIDTH-1]) begin
                        ovf_q  <= 1'b1;
                        quot_q <= ALL_ONES;
                        rem_q  <= raw_lo_q;
                    end else begin
                        ovf_q  <= 1'b0;
                        quot_q <= neg_q_q ? -lo_q : lo_q;
                        rem_q  <= neg_r_q ? -WIDTH'(p_q) : WIDTH'(p_q);
                    end
                end
`endif

                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign ovf       = ovf_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model plus directed literal vectors.
// Honours SEQ_DIVIDER_SIGNED_EN the same way the design does.
module tb_seq_divider;

`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 17;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        ovf;
    logic        div_zero;

    seq_divider #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks;
    int n_pass;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [31:0] n;
        logic [15:0] d;
        logic [15:0] q;
        logic [15:0] r;
        logic        ovf;
        logic        dz;
        int          lat;
        int          acc;
    } exp_t;

    // Reference result straight from integer division.
    function automatic exp_t model(input logic [31:0] n, input logic [15:0] d);
        exp_t   e;
        longint a;
        longint b;
        longint qq;
        longint rr;
        e.n = n; e.d = d; e.acc = 0;
        e.q = 16'hFFFF; e.r = n[15:0]; e.ovf = 1'b0; e.dz = 1'b0; e.lat = 1;
`ifdef SEQ_DIVIDER_SIGNED_EN
        a = longint'($signed(n));
        b = longint'($signed(d));
`else
        a = longint'({32'b0, n});
        b = longint'({48'b0, d});
`endif
        if (b == 0) begin
            e.dz = 1'b1;
        end else begin
            qq = a / b;
            rr = a % b;
`ifdef SEQ_DIVIDER_SIGNED_EN
            if (qq > 32767 || qq < -32768) e.ovf = 1'b1;
            else begin e.q = 16'(qq); e.r = 16'(rr); end
            if (a < 0) a = -a;
            if (b < 0) b = -b;
            if (a < b * 65536) e.lat = LAT;
`else
            if (qq > 65535) e.ovf = 1'b1;
            else begin e.q = 16'(qq); e.r = 16'(rr); e.lat = LAT; end
`endif
        end
        return e;
    endfunction

    // Scoreboard: every cycle a result is presented it is compared with the model.
    exp_t exp_q[$];
    bit   seen;
    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] recon;
        if (rst) begin
            exp_q.delete();
            seen = 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 64'(out_valid), 64'(0));
                end else begin
                    e = exp_q[0];
                    chk("sb_quotient", 64'(quotient), 64'(e.q));
                    chk("sb_remainder", 64'(remainder), 64'(e.r));
                    chk("sb_ovf", 64'(ovf), 64'(e.ovf));
                    chk("sb_div_zero", 64'(div_zero), 64'(e.dz));
                    chk("sb_in_ready_busy", 64'(in_ready), 64'(0));
`ifndef SEQ_DIVIDER_SIGNED_EN
                    if (!e.ovf && !e.dz) begin
                        recon = 64'(quotient) * 64'(e.d) + 64'(remainder);
                        chk("sb_qd_plus_r", recon, 64'(e.n));
                        chk("sb_r_lt_d", 64'(remainder < e.d), 64'(1));
                    end
`endif
                    if (!seen) begin
                        chk("sb_latency", 64'(cyc - e.acc), 64'(e.lat));
                        seen = 1'b1;
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                e = model(dividend, divisor);
                e.acc = cyc;
                exp_q.push_back(e);
            end
        end
    end

    // Hold operands until accepted; returns the cycle the handshake was seen.
    task automatic send(input logic [31:0] n, input logic [15:0] d, output int acc_at);
        bit done;
        done = 1'b0;
        acc_at = -1;
        dividend = n;
        divisor = d;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc_at = cyc;
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_valid(output int seen_at, output bit ok);
        ok = 1'b0;
        seen_at = -1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                seen_at = cyc;
            end
        end
        if (!ok) chk("result_timeout", 64'(0), 64'(1));
    endtask

    task automatic do_op(input logic [31:0] n, input logic [15:0] d,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic ov, output logic dz, output int lat);
        int a;
        int m;
        bit ok;
        out_ready = 1'b1;
        send(n, d, a);
        wait_valid(m, ok);
        q = quotient; r = remainder; ov = ovf; dz = div_zero;
        lat = ok ? (m - a) : -1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic [31:0] n, input logic [15:0] d,
                          input logic [15:0] eq, input logic [15:0] er,
                          input logic eo, input logic ez, input int elat);
        logic [15:0] q;
        logic [15:0] r;
        logic        ov;
        logic        dz;
        int          lat;
        do_op(n, d, q, r, ov, dz, lat);
        chk({name, "_q"}, 64'(q), 64'(eq));
        chk({name, "_r"}, 64'(r), 64'(er));
        chk({name, "_ovf"}, 64'(ov), 64'(eo));
        chk({name, "_dz"}, 64'(dz), 64'(ez));
        chk({name, "_lat"}, 64'(lat), 64'(elat));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        m;
        logic [15:0] q;
        logic [15:0] r;
        logic        ov;
        logic        dz;
        int          lat;
        int          a;
        int          prev;
        int          mv;
        bit          ok;
        logic [31:0] sn[4];
        logic [15:0] sd[4];
        logic [15:0] rd;
        logic [15:0] rh;

        n_checks = 0;
        n_pass = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        dividend = '0;
        divisor = '0;

        // Pin the model against hand-computed values.
        m = model(32'd1000, 16'd7);
        chk("model_1000_7", {32'(m.q), 32'(m.r)}, {32'd142, 32'd6});
        m = model(32'h0000_1234, 16'd0);
        chk("model_div0", {m.q, m.r, 30'(m.dz)}, {16'hFFFF, 16'h1234, 30'd1});
        m = model(32'h0005_0000, 16'd5);
        chk("model_ovf", {m.q, m.r, 30'(m.ovf)}, {16'hFFFF, 16'h0000, 30'd1});

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_outputs", {quotient, remainder, 30'(ovf), 2'(div_zero)}, 64'(0));

        run_op("basic", 32'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 1'b0, LAT);
        run_op("div0", 32'h0000_1234, 16'd0, 16'hFFFF, 16'h1234, 1'b0, 1'b1, 1);
        run_op("ovf", 32'h0005_0000, 16'd5, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1);
`ifdef SEQ_DIVIDER_SIGNED_EN
        run_op("fullrange", 32'hFFFE_0001, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1);
        run_op("signed_m7_2", 32'hFFFF_FFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, LAT);
`else
        run_op("fullrange", 32'hFFFE_0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, LAT);
`endif

        // Backpressure: result must hold for ten cycles.
        out_ready = 1'b0;
        send(32'd1000, 16'd7, a);
        wait_valid(mv, ok);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_quot_rem", {32'(quotient), 32'(remainder)}, {32'd142, 32'd6});
        end

        // Back-to-back stream with in_valid held high.
        sn[0] = 32'd1000;       sd[0] = 16'd7;
        sn[1] = 32'h1234_5678;  sd[1] = 16'h9ABC;
        sn[2] = 32'h00FF_00FF;  sd[2] = 16'h0100;
        sn[3] = 32'd100;        sd[3] = 16'd9;
        out_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            send(sn[i], sd[i], a);
            if (i > 0) chk("b2b_spacing", 64'(a - prev), 64'(LAT + 1));
            prev = a;
        end
        wait_valid(mv, ok);
        @(posedge clk);
        #1;

        // Reset in the middle of a calculation.
        send(32'h1234_5678, 16'h9ABC, a);
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_quotient", 64'(quotient), 64'(0));
        repeat (25) @(posedge clk);
        #1;
        run_op("after_rst", 32'd100, 16'd9, 16'd11, 16'd1, 1'b0, 1'b0, LAT);

        // Random pairs in the non-overflowing unsigned range.
        for (int i = 0; i < 500; i++) begin
            rd = 16'($urandom_range(1, 65535));
            rh = 16'($urandom_range(0, 32'(rd) - 1));
            do_op({rh, 16'($urandom)}, rd, q, r, ov, dz, lat);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("all_retired", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
